// File: rtl/spi_master.sv
// SPI mode-0 master: sends header {~RNW, ADDR} then LEN+1 data bytes MSB first,
// with an SCLK half-period of CLK_DIV system clocks. SCLK, MOSI and CSN are registered.
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       RNW,
  input  logic [6:0] ADDR,
  input  logic [3:0] LEN,
  input  logic [7:0] WD,
  output logic       WD_REQ,
  output logic [7:0] RD,
  output logic       RD_VALID,
  output logic       BUSY,
  output logic       DONE,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       CSN
);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t     state, state_nxt;
  logic [7:0] div_cnt;
  logic [8:0] half_cnt;
  logic       rnw_q;
  logic [3:0] len_q;
  logic [7:0] tx_sh, data_buf, rx_sh;
  logic       div_end, half_last, accept, sclk_rise, sclk_fall, byte_end, last_byte;
  logic [4:0] byte_idx;
  logic [2:0] bit_idx;

  // half_cnt indexes SCLK half-periods: even = low phase, odd = high phase.
  // The extra trailing low half after the last falling edge gives MOSI hold time.
  assign div_end   = (div_cnt == 8'(CLK_DIV - 1));
  assign byte_idx  = half_cnt[8:4];
  assign bit_idx   = half_cnt[3:1];
  assign half_last = (half_cnt == {({1'b0, len_q} + 5'd2), 4'b0000});
  assign last_byte = (byte_idx == ({1'b0, len_q} + 5'd1));
  assign accept    = (state == IDLE) && START;
  assign sclk_rise = (state == SHIFT) && div_end && !half_cnt[0] && !half_last;
  assign sclk_fall = (state == SHIFT) && div_end && half_cnt[0];
  assign byte_end  = sclk_rise && (bit_idx == 3'd7) && (byte_idx != 5'd0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    BUSY      = (state != IDLE);
    DONE      = (state == GAP) && div_end;
    WD_REQ    = (accept && !RNW) || (byte_end && !last_byte && !rnw_q);
    case (state)
      IDLE:    if (START) state_nxt = SETUP;
      SETUP:   if (div_end) state_nxt = SHIFT;
      SHIFT:   if (div_end && half_last) state_nxt = HOLD;
      HOLD:    if (div_end) state_nxt = GAP;
      GAP:     if (div_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_cnt  <= 8'd0;
      half_cnt <= 9'd0;
      rnw_q    <= 1'b0;
      len_q    <= 4'd0;
      SCLK     <= 1'b0;
      CSN      <= 1'b1;
      MOSI     <= 1'b0;
      RD       <= 8'h00;
      RD_VALID <= 1'b0;
    end else begin
      div_cnt <= (state == IDLE || div_end) ? 8'd0 : div_cnt + 8'd1;
      if (state != SHIFT)  half_cnt <= 9'd0;
      else if (div_end)    half_cnt <= half_cnt + 9'd1;
      if (accept) begin
        rnw_q <= RNW;
        len_q <= LEN;
      end
      if (accept)                       CSN <= 1'b0;
      else if (state == HOLD && div_end) CSN <= 1'b1;
      if (sclk_rise)      SCLK <= 1'b1;
      else if (sclk_fall) SCLK <= 1'b0;
      if (state == SETUP && div_end) MOSI <= tx_sh[7];
      else if (sclk_fall) begin
        if (bit_idx != 3'd7) MOSI <= tx_sh[7];
        else if (last_byte)  MOSI <= 1'b0;
        else                 MOSI <= data_buf[7];
      end
      RD_VALID <= byte_end && rnw_q;
      if (byte_end && rnw_q) RD <= {rx_sh[6:0], MISO};
    end
  end

  // data_buf holds the next byte to send; it is refilled at each data byte's 8th rising edge
  always_ff @(posedge CLK) begin
    if (accept) begin
      tx_sh    <= {~RNW, ADDR};
      data_buf <= RNW ? 8'h00 : WD;
    end else if ((state == SETUP && div_end) || (sclk_fall && bit_idx != 3'd7)) begin
      tx_sh <= {tx_sh[6:0], 1'b0};
    end else if (sclk_fall) begin
      tx_sh <= {data_buf[6:0], 1'b0};
    end
    if (byte_end && !last_byte) data_buf <= rnw_q ? 8'h00 : WD;
    if (sclk_rise) rx_sh <= {rx_sh[6:0], MISO};
  end
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: timeline model of every output derived from the transaction
// parameters, randomized transactions, and directed literal checks.
module tb_spi_master;
  localparam int K = 3;

  logic       CLK = 1'b0, RST = 1'b1, START = 1'b0, RNW = 1'b0, MISO = 1'b0;
  logic [6:0] ADDR = '0;
  logic [3:0] LEN = '0;
  logic [7:0] WD = '0;
  logic       WD_REQ, RD_VALID, BUSY, DONE, SCLK, MOSI, CSN;
  logic [7:0] RD;

  spi_master #(.CLK_DIV(K)) dut (
    .CLK(CLK), .RST(RST), .START(START), .RNW(RNW), .ADDR(ADDR), .LEN(LEN), .WD(WD),
    .WD_REQ(WD_REQ), .RD(RD), .RD_VALID(RD_VALID), .BUSY(BUSY), .DONE(DONE),
    .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .CSN(CSN)
  );

  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // transaction model
  logic       m_rnw = 1'b0;
  logic [6:0] m_addr = '0;
  int         m_len = 0;
  logic [7:0] m_wd[16], m_rd[16], tmp_wd[16], tmp_rd[16];
  logic [7:0] m_junk = '0;
  int         start_cyc = -1000000;
  int         n_vec = 0, n_fail = 0;

  // observations kept by the compare process
  logic [63:0] cap;
  int          rise_cnt, wdreq_cnt, done_cnt, rdv_cnt, done_t, rdv_t0, rdv_t1;
  logic [7:0]  rd_model = 8'h00, rd_last;
  logic        prev_sclk = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  function automatic int total_t();
    return (16 * (m_len + 2) + 4) * K;
  endfunction

  function automatic int half_of(input int t);
    if (t >= K + 1 && t <= (16 * (m_len + 2) + 2) * K) return (t - K - 1) / K;
    return -1;
  endfunction

  function automatic logic tx_bit(input int b);
    logic [7:0] bv;
    int j;
    j = b / 8;
    if (j == 0)     bv = {~m_rnw, m_addr};
    else if (m_rnw) bv = 8'h00;
    else            bv = m_wd[j-1];
    return bv[7 - (b % 8)];
  endfunction

  function automatic logic rx_bit(input int b);
    logic [7:0] bv;
    int j;
    j = b / 8;
    bv = (j == 0) ? m_junk : m_rd[j-1];
    return bv[7 - (b % 8)];
  endfunction

  // true in the cycle whose clock edge raises SCLK for the 8th bit of a byte
  function automatic logic rise8(input int t, output int j);
    int h;
    h = half_of(t);
    j = 0;
    if (h < 0 || h >= 16 * (m_len + 2) || (h % 2) != 0) return 1'b0;
    if (((t - K - 1) % K) != K - 1) return 1'b0;
    if (((h / 2) % 8) != 7) return 1'b0;
    j = h / 16;
    return 1'b1;
  endfunction

  int   c_t, c_h, c_n, c_tt, c_j, c_j2;
  logic e_busy, e_done, e_csn, e_sclk, e_mosi, e_wdreq, e_rdv, c_r;

  initial begin
    forever begin
      @(negedge CLK);
      if (RST) begin
        rd_model  = 8'h00;
        prev_sclk = 1'b0;
      end else begin
        c_t  = cyc - start_cyc;
        c_n  = m_len + 2;
        c_tt = total_t();
        c_h  = half_of(c_t);
        if (c_t == 0) begin
          cap = '0; rise_cnt = 0; wdreq_cnt = 0; done_cnt = 0; rdv_cnt = 0;
          done_t = -1; rdv_t0 = -1; rdv_t1 = -1;
        end
        e_busy  = (c_t >= 1 && c_t <= c_tt);
        e_done  = (c_t == c_tt);
        e_csn   = !(c_t >= 1 && c_t <= c_tt - K);
        e_sclk  = (c_h >= 0 && c_h < 16 * c_n && (c_h % 2) == 1);
        e_mosi  = (c_h >= 0 && c_h < 16 * c_n) ? tx_bit(c_h / 2) : 1'b0;
        c_r     = rise8(c_t, c_j);
        e_wdreq = !m_rnw && (c_t == 0 || (c_r && c_j >= 1 && c_j <= c_n - 2));
        c_r     = rise8(c_t - 1, c_j2);
        e_rdv   = m_rnw && c_r && c_j2 >= 1;
        if (e_rdv) rd_model = m_rd[c_j2-1];
        chk("busy", 64'(BUSY), 64'(e_busy));
        chk("done", 64'(DONE), 64'(e_done));
        chk("csn", 64'(CSN), 64'(e_csn));
        chk("sclk", 64'(SCLK), 64'(e_sclk));
        chk("mosi", 64'(MOSI), 64'(e_mosi));
        chk("wd_req", 64'(WD_REQ), 64'(e_wdreq));
        chk("rd_valid", 64'(RD_VALID), 64'(e_rdv));
        chk("rd", 64'(RD), 64'(rd_model));
        if (SCLK && !prev_sclk) begin
          cap = {cap[62:0], MOSI};
          rise_cnt++;
        end
        prev_sclk = SCLK;
        if (WD_REQ) wdreq_cnt++;
        if (DONE) begin done_cnt++; done_t = c_t; end
        if (RD_VALID) begin
          if (rdv_cnt == 0) rdv_t0 = c_t;
          rdv_t1 = c_t;
          rdv_cnt++;
          rd_last = RD;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
      START = 1'b0;
      MISO  = 1'($urandom);
    end
  endtask

  task automatic run_txn(input logic rnw, input logic [6:0] addr, input int len,
                         input int busy_t, input bit done_st, input int abort_t);
    int   tt, h, widx;
    logic req;
    req = 1'b0;
    widx = 0;
    @(posedge CLK); #1;
    m_rnw = rnw; m_addr = addr; m_len = len; m_wd = tmp_wd; m_rd = tmp_rd;
    m_junk = 8'($urandom);
    start_cyc = cyc;
    tt = total_t();
    RNW = rnw; ADDR = addr; LEN = 4'(len);
    for (int t = 0; t <= tt + 3; t++) begin
      if (t > 0) begin
        @(posedge CLK); #1;
        if (req) widx++;
        RNW = 1'($urandom); ADDR = 7'($urandom); LEN = 4'($urandom);
      end
      START = (t == 0) || (t == busy_t) || (done_st && t == tt);
      WD = (widx <= len) ? tmp_wd[widx] : 8'($urandom);
      h = half_of(t);
      MISO = (h >= 0 && h < 16 * (len + 2)) ? rx_bit(h / 2) : 1'($urandom);
      if (t == abort_t) begin
        chk("pre_rst_sclk", 64'(SCLK), 64'd1);
        #2 RST = 1'b1;
        #1;
        chk("rst_sclk", 64'(SCLK), 64'd0);
        chk("rst_csn", 64'(CSN), 64'd1);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_done", 64'(DONE), 64'd0);
        @(negedge CLK);
        @(posedge CLK); #1;
        start_cyc = -1000000;
        START = 1'b0;
        RST = 1'b0;
        return;
      end
      @(negedge CLK);
      req = WD_REQ;
    end
    START = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin tmp_wd[k] = 8'h00; tmp_rd[k] = 8'h00; end
    m_wd = tmp_wd; m_rd = tmp_rd;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_csn", 64'(CSN), 64'd1);
    chk("reset_sclk", 64'(SCLK), 64'd0);
    chk("reset_mosi", 64'(MOSI), 64'd0);
    chk("reset_rd", 64'(RD), 64'h00);
    chk("reset_busy", 64'(BUSY), 64'd0);
    chk("reset_done", 64'(DONE), 64'd0);
    chk("reset_rdv", 64'(RD_VALID), 64'd0);
    chk("reset_wdreq", 64'(WD_REQ), 64'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    idle(3);

    tmp_wd[0] = 8'hA5;
    run_txn(1'b0, 7'h12, 0, -1, 1'b0, -1);
    chk("w_bits", 64'(cap[15:0]), 64'h92A5);
    chk("w_rises", 64'(rise_cnt), 64'd16);
    chk("w_wdreq", 64'(wdreq_cnt), 64'd1);
    chk("w_done", 64'(done_cnt), 64'd1);
    chk("w_len", 64'(done_t), 64'd108);
    chk("w_csn", 64'(CSN), 64'd1);

    tmp_rd[0] = 8'h3C;
    run_txn(1'b1, 7'h05, 0, -1, 1'b0, -1);
    chk("r_hdr", 64'(cap[15:8]), 64'h05);
    chk("r_rdv", 64'(rdv_cnt), 64'd1);
    chk("r_rd", 64'(rd_last), 64'h3C);
    chk("r_wdreq", 64'(wdreq_cnt), 64'd0);

    tmp_wd[0] = 8'h11; tmp_wd[1] = 8'h22; tmp_wd[2] = 8'h33;
    run_txn(1'b0, 7'h40, 2, -1, 1'b0, -1);
    chk("w3_wdreq", 64'(wdreq_cnt), 64'd3);
    chk("w3_data", 64'(cap[23:0]), 64'h112233);
    chk("w3_rises", 64'(rise_cnt), 64'd32);

    tmp_rd[0] = 8'hF0; tmp_rd[1] = 8'h0F;
    run_txn(1'b1, 7'h33, 1, -1, 1'b0, -1);
    chk("r2_rdv", 64'(rdv_cnt), 64'd2);
    chk("r2_last", 64'(rd_last), 64'h0F);
    chk("r2_gap", 64'(rdv_t1 - rdv_t0), 64'd48);

    tmp_wd[0] = 8'h5A;
    run_txn(1'b0, 7'h21, 0, 40, 1'b1, -1);
    idle(20);
    chk("ign_busy", 64'(BUSY), 64'd0);
    chk("ign_rises", 64'(rise_cnt), 64'd16);
    chk("ign_done", 64'(done_cnt), 64'd1);

    run_txn(1'b0, 7'h55, 3, -1, 1'b0, 10 * K + 2);
    chk("abort_done", 64'(done_cnt), 64'd0);
    idle(3);
    tmp_rd[0] = 8'h81; tmp_rd[1] = 8'h7E;
    run_txn(1'b1, 7'h2A, 1, -1, 1'b0, -1);
    chk("post_rst_rdv", 64'(rdv_cnt), 64'd2);
    chk("post_rst_done", 64'(done_cnt), 64'd1);

    for (int i = 0; i < 15; i++) begin
      for (int k = 0; k < 16; k++) begin
        tmp_wd[k] = 8'($urandom);
        tmp_rd[k] = 8'($urandom);
      end
      run_txn(1'($urandom), 7'($urandom), $urandom_range(0, 15),
              (i % 3 == 0) ? $urandom_range(1, 100) : -1, (i % 4 == 1), -1);
      idle($urandom_range(0, 3));
    end
    idle(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
